// File: rtl/imem_loader.sv
// Byte-stream loader for the MIPS instruction memory: packs bytes big-endian into words,
// writes them at consecutive addresses and holds the core in reset until the load completes.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic              byte_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic              err_partial,
  output logic              err_overflow
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  localparam logic [ADDR_W:0] MAX_WORDS = (ADDR_W+1)'(1) << ADDR_W;

  state_t          state_q;
  logic [1:0]      idx_q;
  logic [31:0]     word_q;
  logic [31:0]     word_d;
  logic            last_q;
  logic [ADDR_W:0] count_d;

  // Merge the incoming byte into the partial word; the first byte lands in the MSB.
  always_comb begin
    word_d = word_q;
    case (idx_q)
      2'd0:    word_d[31:24] = byte_in;
      2'd1:    word_d[23:16] = byte_in;
      2'd2:    word_d[15:8]  = byte_in;
      default: word_d[7:0]   = byte_in;
    endcase
  end

  assign count_d = word_count + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= 2'd0;
      word_q       <= 32'h0;
      last_q       <= 1'b0;
      byte_ready   <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= 32'h0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      word_count   <= '0;
      err_partial  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q      <= LOAD;
            idx_q        <= 2'd0;
            word_q       <= 32'h0;
            last_q       <= 1'b0;
            byte_ready   <= 1'b1;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            word_count   <= '0;
            err_partial  <= 1'b0;
            err_overflow <= 1'b0;
          end
        end
        LOAD: begin
          if (byte_valid && byte_ready) begin
            if (idx_q == 2'd3 || byte_last) begin
              // A final byte before the word is full leaves the low bytes zero.
              state_q     <= WRITE;
              byte_ready  <= 1'b0;
              imem_we     <= 1'b1;
              imem_addr   <= word_count[ADDR_W-1:0];
              imem_wdata  <= word_d;
              last_q      <= byte_last;
              err_partial <= byte_last && (idx_q != 2'd3);
            end else begin
              word_q <= word_d;
              idx_q  <= idx_q + 2'd1;
            end
          end
        end
        WRITE: begin
          word_count <= count_d;
          idx_q      <= 2'd0;
          word_q     <= 32'h0;
          if (last_q || count_d == MAX_WORDS) begin
            state_q      <= DONE;
            done         <= 1'b1;
            cpu_hold     <= 1'b0;
            err_overflow <= !last_q;
          end else begin
            state_q    <= LOAD;
            byte_ready <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a queue-based reference model checked every cycle,
// plus literal expectations on the words captured from the imem write port.
module tb_imem_loader;

  localparam int AW   = 2;
  localparam int MAXW = 1 << AW;
  localparam int TIMEOUT = 50;

  logic          clk = 1'b0;
  logic          reset, start, byteValid, byteLast;
  logic [7:0]    byteIn;
  logic          byteReady, imemWe, cpuHold, done, errPartial, errOverflow;
  logic [AW-1:0] imemAddr;
  logic [31:0]   imemWdata;
  logic [AW:0]   wordCount;

  int checks   = 0;
  int failures = 0;
  bit checkEn  = 1'b0;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .byte_in(byteIn), .byte_valid(byteValid), .byte_ready(byteReady), .byte_last(byteLast),
    .imem_we(imemWe), .imem_addr(imemAddr), .imem_wdata(imemWdata),
    .cpu_hold(cpuHold), .done(done), .word_count(wordCount),
    .err_partial(errPartial), .err_overflow(errOverflow)
  );

  // Reference model: a load phase, a queue of bytes received for the current word,
  // and the expected value of every output after each rising edge.
  typedef enum {M_IDLE, M_LOAD, M_WRITE, M_DONE} mphase_t;
  mphase_t     mPhase;
  logic [7:0]  pend[$];
  bit          lastTaken;
  int          eCount;
  logic        eReady, eWe, eHold, eDone, ePartial, eOverflow;
  logic [AW-1:0] eAddr;
  logic [31:0] eWdata;

  always @(posedge clk) begin
    if (reset) begin
      mPhase = M_IDLE; pend.delete(); lastTaken = 0; eCount = 0;
      eReady = 0; eWe = 0; eHold = 1; eDone = 0; ePartial = 0; eOverflow = 0;
      eAddr = '0; eWdata = 32'h0;
    end else begin
      eWe = 0;
      case (mPhase)
        M_IDLE, M_DONE: if (start) begin
          mPhase = M_LOAD; pend.delete(); eCount = 0;
          eReady = 1; eHold = 1; eDone = 0; ePartial = 0; eOverflow = 0;
        end
        M_LOAD: if (byteValid) begin
          pend.push_back(byteIn);
          if (pend.size() == 4 || byteLast) begin
            ePartial = byteLast && pend.size() < 4;
            while (pend.size() < 4) pend.push_back(8'h00);
            eWdata = {pend[0], pend[1], pend[2], pend[3]};
            eAddr  = AW'(eCount);
            eWe = 1; eReady = 0; lastTaken = byteLast;
            pend.delete();
            mPhase = M_WRITE;
          end
        end
        M_WRITE: begin
          eCount++;
          if (lastTaken || eCount == MAXW) begin
            mPhase = M_DONE; eDone = 1; eHold = 0; eOverflow = !lastTaken;
          end else begin
            mPhase = M_LOAD; eReady = 1;
          end
        end
        default: mPhase = M_IDLE;
      endcase
    end
  end

  // Every-cycle comparison; address and data only matter on a write cycle.
  always @(negedge clk) begin
    logic [42:0] expV, actV;
    if (checkEn) begin
      expV = {eReady, eWe, eAddr & {AW{eWe}}, eWdata & {32{eWe}}, eHold, eDone,
              (AW+1)'(eCount), ePartial, eOverflow};
      actV = {byteReady, imemWe, imemAddr & {AW{eWe}}, imemWdata & {32{eWe}}, cpuHold, done,
              wordCount, errPartial, errOverflow};
      checks++;
      if (actV !== expV) begin
        failures++;
        $display("[TB] FAIL cycleModel t=%0t actual=%h required=%h", $time, actV, expV);
      end
    end
  end

  // Capture of the imem write port for the literal checks.
  logic [31:0] shadow [MAXW];
  int          writeCount;

  always @(negedge clk) begin
    if (imemWe) begin
      shadow[imemAddr] = imemWdata;
      writeCount++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clearShadow();
    for (int i = 0; i < MAXW; i++) shadow[i] = 32'h0;
    writeCount = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      byteValid = 0; byteLast = 0; start = 0;
    end
    #1;
  endtask

  task automatic pulseStart();
    @(negedge clk);
    start = 1; byteValid = 0; byteLast = 0;
    @(negedge clk);
    start = 0;
  endtask

  // Presents one byte and holds it until a cycle where the loader is ready.
  task automatic applyStimulus(input logic [7:0] b, input logic l);
    int guard = 0;
    @(negedge clk);
    byteIn = b; byteValid = 1; byteLast = l;
    while (!byteReady && guard < TIMEOUT) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= TIMEOUT) begin
      checks++; failures++;
      $display("[TB] FAIL handshakeTimeout actual=ready_low required=ready_high");
    end
  endtask

  task automatic gap();
    @(negedge clk);
    byteValid = 0; byteLast = 0;
  endtask

  logic [7:0] progA [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A};
  logic [7:0] progB [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB};

  initial begin
    reset = 1; start = 0; byteValid = 1; byteLast = 0; byteIn = 8'hAB;
    clearShadow();
    @(posedge clk);
    #1 checkEn = 1;

    // Reset held with a live stream: everything at reset values.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetReady", 32'(byteReady), 32'd0);
    checkOutput("resetHold",  32'(cpuHold),   32'd1);
    checkOutput("resetWe",    32'(imemWe),    32'd0);
    checkOutput("resetAddr",  32'(imemAddr),  32'd0);
    checkOutput("resetData",  imemWdata,      32'h0);
    checkOutput("resetFlags", {28'h0, done, errPartial, errOverflow, 1'b0}, 32'h0);
    checkOutput("resetCount", 32'(wordCount), 32'd0);
    @(negedge clk);
    reset = 0;
    idle(0);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("noStartWrites", 32'(writeCount), 32'd0);
    checkOutput("noStartReady",  32'(byteReady),  32'd0);

    // Two full words.
    clearShadow();
    pulseStart();
    for (int i = 0; i < 8; i++) applyStimulus(progA[i], i == 7);
    idle(3);
    checkOutput("t2Writes", 32'(writeCount), 32'd2);
    checkOutput("t2Word0",  shadow[0], 32'h20080005);
    checkOutput("t2Word1",  shadow[1], 32'h2009000A);
    checkOutput("t2Count",  32'(wordCount), 32'd2);
    checkOutput("t2Done",   {30'h0, done, cpuHold}, 32'b10);
    checkOutput("t2Errors", {30'h0, errPartial, errOverflow}, 32'h0);

    // Same program with gaps; the first byte of word 1 waits through WRITE.
    clearShadow();
    pulseStart();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(progA[i], i == 7);
      if (i != 3 && i != 7) gap();
    end
    idle(3);
    checkOutput("t3Writes", 32'(writeCount), 32'd2);
    checkOutput("t3Word0",  shadow[0], 32'h20080005);
    checkOutput("t3Word1",  shadow[1], 32'h2009000A);

    // Final byte mid-word: zero padded, partial flag.
    clearShadow();
    pulseStart();
    for (int i = 0; i < 6; i++) applyStimulus(progB[i], i == 5);
    idle(3);
    checkOutput("t4Word0",   shadow[0], 32'h11223344);
    checkOutput("t4Word1",   shadow[1], 32'hAABB0000);
    checkOutput("t4Partial", 32'(errPartial), 32'd1);
    checkOutput("t4Done",    32'(done), 32'd1);

    // Capacity reached without a final byte; extra bytes stay unconsumed.
    clearShadow();
    pulseStart();
    for (int i = 0; i < 16; i++) applyStimulus(8'(i), 1'b0);
    @(negedge clk);
    byteIn = 8'h99; byteValid = 1; byteLast = 0;
    idle(0);
    repeat (6) @(negedge clk);
    byteValid = 0;
    idle(2);
    checkOutput("t5Writes",   32'(writeCount), 32'd4);
    checkOutput("t5Word0",    shadow[0], 32'h00010203);
    checkOutput("t5Word3",    shadow[3], 32'h0C0D0E0F);
    checkOutput("t5Overflow", 32'(errOverflow), 32'd1);
    checkOutput("t5Count",    32'(wordCount), 32'd4);
    checkOutput("t5Ready",    32'(byteReady), 32'd0);

    // Reset mid-word (with a coincident start): nothing written, core held.
    clearShadow();
    pulseStart();
    applyStimulus(8'h55, 1'b0);
    applyStimulus(8'h66, 1'b0);
    @(negedge clk);
    reset = 1; start = 1; byteValid = 0;
    @(negedge clk);
    reset = 0; start = 0;
    idle(2);
    checkOutput("t6NoWrite", 32'(writeCount), 32'd0);
    checkOutput("t6Hold",    32'(cpuHold), 32'd1);
    checkOutput("t6Ready",   32'(byteReady), 32'd0);
    pulseStart();
    applyStimulus(8'hAB, 1'b0);
    applyStimulus(8'hCD, 1'b0);
    applyStimulus(8'hEF, 1'b0);
    applyStimulus(8'h01, 1'b1);
    idle(3);
    checkOutput("t6Writes", 32'(writeCount), 32'd1);
    checkOutput("t6Word0",  shadow[0], 32'hABCDEF01);
    checkOutput("t6Done",   {30'h0, done, errPartial}, 32'b10);

    checkEn = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
